// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises bitstream words MSB-first onto a ccff chain and captures tail readback.
// Optional CRC-16-CCITT check word after the chain is filled: define CCFF_CRC_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
`ifdef CCFF_CRC_EN
    CHECK,
`endif
    DONE
  } state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              head_q, head_d;
  logic              en_q, en_d;
  logic [WORD_W-1:0] rb_q, rb_d;
`ifdef CCFF_CRC_EN
  logic [15:0]       crc_q, crc_d;
  logic              err_q, err_d;
`endif
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    head_d  = head_q;
    en_d    = 1'b0;
    rb_d    = en_q ? {rb_q[WORD_W-2:0], ccff_tail} : rb_q;
`ifdef CCFF_CRC_EN
    crc_d   = crc_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE, DONE: if (cfg_start) begin
        state_d = LOAD;
        cnt_d   = '0;
`ifdef CCFF_CRC_EN
        crc_d   = 16'hFFFF;
        err_d   = 1'b0;
`endif
      end
      LOAD: if (cfg_valid) begin
        sreg_d  = cfg_data;
        wcnt_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        head_d = sreg_q[WORD_W-1];
        en_d   = 1'b1;
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + 1'b1;
        wcnt_d = wcnt_q + 1'b1;
`ifdef CCFF_CRC_EN
        crc_d  = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ sreg_q[WORD_W-1]}} & 16'h1021);
`endif
        // Chain-full takes priority so a partial last word drops its unused low bits.
        if (cnt_q == CW'(CHAIN_LEN - 1))
`ifdef CCFF_CRC_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        else if (wcnt_q == WW'(WORD_W - 1))
          state_d = LOAD;
      end
`ifdef CCFF_CRC_EN
      CHECK: if (cfg_valid) begin
        err_d   = 16'(cfg_data) != crc_q;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      rb_q    <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
      rb_q    <= rb_d;
    end
  end
`ifdef CCFF_CRC_EN
  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      crc_q <= 16'hFFFF;
      err_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      err_q <= err_d;
    end
  end
  assign err       = err_q;
  assign cfg_ready = (state_q == LOAD) || (state_q == CHECK);
`else
  assign err       = 1'b0;
  assign cfg_ready = state_q == LOAD;
`endif
  assign ccff_head    = head_q;
  assign chain_clk_en = en_q;
  assign rb_data      = rb_q;
  assign busy         = (state_q == LOAD) || (state_q == SHIFT);
  assign done         = state_q == DONE;
endmodule
